seg7_capture: RTL and testbench



---
 rtl/seg7_pkg.sv | 55 +++++
 rtl/seg7_decode.sv | 16 +
 rtl/seg7_capture.sv | 158 +++++++++++++++
 tb/tb_seg7_capture.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment capture path: hex segment patterns,
// FSM state type and the pattern-to-nibble lookup used by both encoder and decoder.
package seg7_pkg;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;

    localparam int SEG_DP_BIT = 7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } cap_state_e;

    // Returns {legal, nibble}; anything outside the 16 hex glyphs (blank included) is illegal.
    function automatic logic [4:0] seg_to_nibble(input logic [6:0] pat);
        logic [4:0] r;
        case (pat)
            SEG_0:   r = {1'b1, 4'h0};
            SEG_1:   r = {1'b1, 4'h1};
            SEG_2:   r = {1'b1, 4'h2};
            SEG_3:   r = {1'b1, 4'h3};
            SEG_4:   r = {1'b1, 4'h4};
            SEG_5:   r = {1'b1, 4'h5};
            SEG_6:   r = {1'b1, 4'h6};
            SEG_7:   r = {1'b1, 4'h7};
            SEG_8:   r = {1'b1, 4'h8};
            SEG_9:   r = {1'b1, 4'h9};
            SEG_A:   r = {1'b1, 4'hA};
            SEG_B:   r = {1'b1, 4'hB};
            SEG_C:   r = {1'b1, 4'hC};
            SEG_D:   r = {1'b1, 4'hD};
            SEG_E:   r = {1'b1, 4'hE};
            SEG_F:   r = {1'b1, 4'hF};
            default: r = 5'b0_0000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 7-segment pattern decoder: gfedcba in, hex nibble plus legal flag out.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] nibble_o,
    output logic       legal_o
);

    logic [4:0] lookup;

    assign lookup   = seg_to_nibble(seg_i);
    assign legal_o  = lookup[4];
    assign nibble_o = lookup[3:0];

endmodule

// File: rtl/seg7_capture.sv
// Multiplexed 7-segment bus capture: synchronises segment/enable lines, waits for a
// stable one-hot pattern, decodes it and publishes per-digit value, dp and status flags.
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int unsigned NDIG   = 4,
    parameter int unsigned STABLE = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           segs,
    input  logic [NDIG-1:0]      dig_en,
    output logic [4*NDIG-1:0]    value,
    output logic [NDIG-1:0]      dp,
    output logic [NDIG-1:0]      digit_valid,
    output logic [NDIG-1:0]      bad_digit,
    output logic                 upd,
    output logic                 frame_done
);

    localparam logic [7:0] STABLE_C = 8'(STABLE);

    logic [7:0]        seg_m_q, seg_s_q, seg_p_q;
    logic [NDIG-1:0]   en_m_q, en_s_q, en_p_q;

    cap_state_e        state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [4*NDIG-1:0] value_q, value_d;
    logic [NDIG-1:0]   dp_q, dp_d;
    logic [NDIG-1:0]   valid_q, valid_d;
    logic [NDIG-1:0]   bad_q, bad_d;
    logic [NDIG-1:0]   seen_q, seen_d;
    logic              upd_q, upd_d;
    logic              frame_q, frame_d;

    logic              capture;
    logic              en_onehot;
    logic              same;
    logic [3:0]        dec_nibble;
    logic              dec_legal;

    seg7_decode u_decode (
        .seg_i    (seg_s_q[6:0]),
        .nibble_o (dec_nibble),
        .legal_o  (dec_legal)
    );

    assign en_onehot = (en_s_q != '0) && ((en_s_q & (en_s_q - 1'b1)) == '0);
    assign same      = (seg_s_q == seg_p_q) && (en_s_q == en_p_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en_onehot) begin
                    state_d = ST_SETTLE;
                    cnt_d   = 8'd1;
                end
            end
            ST_SETTLE: begin
                if (same) begin
                    cnt_d = cnt_q + 8'd1;
                end else if (!en_onehot) begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = 8'd1;
                end
            end
            ST_HOLD: begin
                if (!same) begin
                    state_d = en_onehot ? ST_SETTLE : ST_IDLE;
                    cnt_d   = en_onehot ? 8'd1 : 8'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
        // Entering or continuing a settle that hits the threshold captures this cycle,
        // which also covers STABLE=1 capturing on the very first qualifying sample.
        if (state_d == ST_SETTLE && cnt_d == STABLE_C) begin
            capture = 1'b1;
            state_d = ST_HOLD;
        end
    end

    always_comb begin
        value_d = value_q;
        dp_d    = dp_q;
        valid_d = valid_q;
        bad_d   = bad_q;
        upd_d   = capture;
        frame_d = &seen_q;
        // A full mask clears first so a capture landing in the same cycle is kept.
        seen_d  = (&seen_q) ? '0 : seen_q;
        for (int k = 0; k < int'(NDIG); k++) begin
            if (capture && en_s_q[k]) begin
                dp_d[k]   = seg_s_q[SEG_DP_BIT];
                seen_d[k] = 1'b1;
                if (dec_legal) begin
                    value_d[4*k +: 4] = dec_nibble;
                    valid_d[k]        = 1'b1;
                    bad_d[k]          = 1'b0;
                end else begin
                    bad_d[k] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_m_q <= '0;
            seg_s_q <= '0;
            seg_p_q <= '0;
            en_m_q  <= '0;
            en_s_q  <= '0;
            en_p_q  <= '0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            value_q <= '0;
            dp_q    <= '0;
            valid_q <= '0;
            bad_q   <= '0;
            seen_q  <= '0;
            upd_q   <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            seg_m_q <= segs;
            seg_s_q <= seg_m_q;
            seg_p_q <= seg_s_q;
            en_m_q  <= dig_en;
            en_s_q  <= en_m_q;
            en_p_q  <= en_s_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            value_q <= value_d;
            dp_q    <= dp_d;
            valid_q <= valid_d;
            bad_q   <= bad_d;
            seen_q  <= seen_d;
            upd_q   <= upd_d;
            frame_q <= frame_d;
        end
    end

    assign value       = value_q;
    assign dp          = dp_q;
    assign digit_valid = valid_q;
    assign bad_digit   = bad_q;
    assign upd         = upd_q;
    assign frame_done  = frame_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture (NDIG=4, STABLE=3) with hand-computed expectations.
module tb_seg7_capture;

    logic        clk;
    logic        rst_n;
    logic [7:0]  segs;
    logic [3:0]  dig_en;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  digit_valid;
    logic [3:0]  bad_digit;
    logic        upd;
    logic        frame_done;

    int checks;
    int errors;
    int upd_cnt;
    int first_upd;
    int frame_cnt;
    int frame_at;

    seg7_capture #(.NDIG(4), .STABLE(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .segs        (segs),
        .dig_en      (dig_en),
        .value       (value),
        .dp          (dp),
        .digit_valid (digit_valid),
        .bad_digit   (bad_digit),
        .upd         (upd),
        .frame_done  (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive enables and segs (alternating seg_a/seg_b each cycle) for n cycles;
    // cycle numbers count rising edges after the inputs were applied.
    task automatic drive(input logic [3:0] en, input logic [7:0] seg_a,
                         input logic [7:0] seg_b, input int n);
        upd_cnt   = 0;
        first_upd = 0;
        frame_cnt = 0;
        frame_at  = 0;
        for (int i = 0; i < n; i++) begin
            dig_en = en;
            segs   = (i % 2 == 1) ? seg_b : seg_a;
            @(posedge clk);
            #1;
            if (upd) begin
                upd_cnt++;
                if (first_upd == 0) first_upd = i + 1;
            end
            if (frame_done) begin
                frame_cnt++;
                frame_at = i + 1;
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        segs   = 8'h00;
        dig_en = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_value", 32'(value), 32'h0);
        check_eq("rst_flags", 32'({dp, digit_valid, bad_digit, upd, frame_done}), 32'h0);
        rst_n = 1'b1;
        drive(4'b0000, 8'h00, 8'h00, 4);
        check_eq("idle_no_upd", 32'(upd_cnt), 32'd0);

        // Single legal capture: digit 0 shows "2"
        drive(4'b0001, 8'h5B, 8'h5B, 10);
        check_eq("leg_upd_cnt", 32'(upd_cnt), 32'd1);
        check_eq("leg_latency", 32'(first_upd), 32'd5);
        check_eq("leg_value", 32'(value), 32'h0002);
        check_eq("leg_valid", 32'(digit_valid), 32'b0001);
        check_eq("leg_dp", 32'(dp), 32'b0000);

        // Full frame: 3, 4, 5 with dp, F
        drive(4'b0001, 8'h4F, 8'h4F, 8);
        check_eq("fr0_upd", 32'(upd_cnt), 32'd1);
        check_eq("fr0_frame", 32'(frame_cnt), 32'd0);
        drive(4'b0010, 8'h66, 8'h66, 8);
        check_eq("fr1_frame", 32'(frame_cnt), 32'd0);
        drive(4'b0100, 8'hED, 8'hED, 8);
        check_eq("fr2_frame", 32'(frame_cnt), 32'd0);
        drive(4'b1000, 8'h71, 8'h71, 8);
        check_eq("fr3_upd_at", 32'(first_upd), 32'd5);
        check_eq("fr3_frame_cnt", 32'(frame_cnt), 32'd1);
        check_eq("fr3_frame_at", 32'(frame_at), 32'd6);
        check_eq("fr_value", 32'(value), 32'hF543);
        check_eq("fr_dp", 32'(dp), 32'b0100);
        check_eq("fr_valid", 32'(digit_valid), 32'b1111);
        check_eq("fr_bad", 32'(bad_digit), 32'b0000);

        // Illegal pattern on digit 1 after a legal "1"
        drive(4'b0010, 8'h06, 8'h06, 8);
        check_eq("ill_pre_value", 32'(value), 32'hF513);
        drive(4'b0010, 8'h49, 8'h49, 8);
        check_eq("ill_upd", 32'(upd_cnt), 32'd1);
        check_eq("ill_bad", 32'(bad_digit), 32'b0010);
        check_eq("ill_value", 32'(value), 32'hF513);
        check_eq("ill_valid", 32'(digit_valid), 32'b1111);
        check_eq("ill_frame", 32'(frame_cnt), 32'd0);

        // Glitching segments on digit 0, then a steady "1"
        drive(4'b0001, 8'h3F, 8'h06, 20);
        check_eq("glitch_no_upd", 32'(upd_cnt), 32'd1 - 32'd1);
        check_eq("glitch_value", 32'(value), 32'hF513);
        drive(4'b0001, 8'h06, 8'h06, 10);
        check_eq("steady_upd", 32'(upd_cnt), 32'd1);
        check_eq("steady_value", 32'(value), 32'hF511);

        // Enable faults: multi-hot then none, then the same digit again
        drive(4'b0011, 8'h06, 8'h06, 10);
        check_eq("multihot_upd", 32'(upd_cnt), 32'd0);
        drive(4'b0000, 8'h06, 8'h06, 10);
        check_eq("zero_en_upd", 32'(upd_cnt), 32'd0);
        check_eq("fault_value", 32'(value), 32'hF511);
        check_eq("fault_bad", 32'(bad_digit), 32'b0010);
        drive(4'b0001, 8'h06, 8'h06, 10);
        check_eq("recap_upd", 32'(upd_cnt), 32'd1);
        check_eq("recap_at", 32'(first_upd), 32'd5);
        check_eq("recap_frame", 32'(frame_cnt), 32'd0);

        // Reset while settling on digit 2
        drive(4'b0100, 8'h7F, 8'h7F, 3);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_value", 32'(value), 32'h0);
        check_eq("midrst_flags", 32'({dp, digit_valid, bad_digit, upd, frame_done}), 32'h0);
        #1;
        rst_n = 1'b1;
        drive(4'b0100, 8'h7F, 8'h7F, 10);
        check_eq("postrst_upd", 32'(upd_cnt), 32'd1);
        check_eq("postrst_at", 32'(first_upd), 32'd5);
        check_eq("postrst_value", 32'(value), 32'h0800);
        check_eq("postrst_valid", 32'(digit_valid), 32'b0100);
        check_eq("postrst_bad", 32'(bad_digit), 32'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
